// File: rtl/counter_time_param.sv
// Round timer: prescaled up/down counter with pause, reload and saturation.
// Optional low-time warning enabled by defining COUNTER_TIME_WARN_EN.
module counter_time_param #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int TIME_W    = 4,
  parameter int MAX_TIME  = 15,
  parameter int WARN_TIME = 3
) (
  input  logic              clkt,
  input  logic              R,
  input  logic              E,
  input  logic              down,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  output logic [TIME_W-1:0] tempo,
  output logic              tick,
  output logic              end_time,
  output logic              warn
);

  localparam int PRE_W = $clog2(TICK_DIV);

  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(TICK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE =
    PRE_W'(1);
  localparam logic [TIME_W-1:0] MAX_T =
    TIME_W'(MAX_TIME);
  localparam logic [TIME_W-1:0] ONE_T =
    TIME_W'(1);

  logic [PRE_W-1:0]  pre;
  logic              dir;
  logic              done;
  logic [TIME_W-1:0] sat_val;
  logic              sat_term;
  logic [TIME_W-1:0] step_val;
  logic              step_term;

  // Reload is clamped and checked against the end of the new direction.
  always_comb begin
    sat_val  = (load_val > MAX_T) ? MAX_T : load_val;
    sat_term = down ? (sat_val == '0)
                    : (sat_val == MAX_T);
    step_val  = dir ? (tempo - ONE_T)
                    : (tempo + ONE_T);
    step_term = dir ? (step_val == '0)
                    : (step_val == MAX_T);
  end

  always_ff @(posedge clkt) begin
    if (R) begin
      pre   <= '0;
      dir   <= down;
      tick  <= 1'b0;
      done  <= 1'b0;
      tempo <= down ? MAX_T : '0;
    end else if (load) begin
      pre   <= '0;
      dir   <= down;
      tick  <= 1'b0;
      done  <= sat_term;
      tempo <= sat_val;
    end else if (E && !done) begin
      if (pre == PRE_LAST) begin
        pre   <= '0;
        tick  <= 1'b1;
        tempo <= step_val;
        done  <= step_term;
      end else begin
        pre  <= pre + PRE_ONE;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  assign end_time = done;

`ifdef COUNTER_TIME_WARN_EN
  localparam logic [TIME_W-1:0] WARN_T =
    TIME_W'(WARN_TIME);

  assign warn = dir & ~done & (tempo <= WARN_T);
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_counter_time_param.sv
// Bench for counter_time_param: directed scenarios plus random
// control, checked against an elapsed-time model of the round.
module tb_counter_time_param;

  localparam int TD = 4;
  localparam int MT = 15;
  localparam int WT = 3;

  logic       clk = 1'b0;
  logic       R = 1'b0;
  logic       E = 1'b0;
  logic       down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] lv = '0;
  logic [4:0] lv5 = '0;
  logic [3:0] tempo;
  logic       tick;
  logic       end_time;
  logic       warn;
  logic [4:0] tempo5;
  logic       tick5;
  logic       end5;
  logic       warn5;

  int n_vec = 0;
  int n_err = 0;

  // reference model: round = start value plus elapsed
  // enabled cycles, converted to whole ticks
  int m_start = 0;
  bit m_dir = 0;
  int m_cnt = 0;
  bit m_done = 0;
  bit m_tick = 0;
  int m_tempo = 0;

  always #5 clk = ~clk;

  counter_time_param #(
    .TICK_DIV(TD), .TIME_W(4),
    .MAX_TIME(MT), .WARN_TIME(WT)
  ) dut (
    .clkt(clk), .R(R), .E(E), .down(down),
    .load(load), .load_val(lv),
    .tempo(tempo), .tick(tick),
    .end_time(end_time), .warn(warn)
  );

  counter_time_param #(
    .TICK_DIV(TD), .TIME_W(5),
    .MAX_TIME(MT), .WARN_TIME(WT)
  ) dut5 (
    .clkt(clk), .R(R), .E(E), .down(down),
    .load(load), .load_val(lv5),
    .tempo(tempo5), .tick(tick5),
    .end_time(end5), .warn(warn5)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %0d expected %0d",
             tag, got, exp);
    end
  endtask

  function automatic int term(bit d);
    return d ? 0 : MT;
  endfunction

  task automatic cyc();
    bit was_ld;
    int sat5;
    was_ld = load && !R;
    sat5 = (int'(lv5) > MT) ? MT : int'(lv5);
    @(posedge clk);
    if (R) begin
      m_dir = down;
      m_start = down ? MT : 0;
      m_cnt = 0;
      m_done = 0;
      m_tick = 0;
    end else if (load) begin
      m_dir = down;
      m_start = (int'(lv) > MT) ? MT : int'(lv);
      m_cnt = 0;
      m_tick = 0;
      m_done = (m_start == term(m_dir));
    end else if (E && !m_done) begin
      m_cnt++;
      m_tick = (m_cnt % TD == 0);
    end else begin
      m_tick = 0;
    end
    m_tempo = m_dir ? m_start - m_cnt / TD
                    : m_start + m_cnt / TD;
    if (!R && !load && m_tick)
      m_done = (m_tempo == term(m_dir));
    #1;
    chk("tempo", 32'(tempo), 32'(m_tempo));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("end_time", 32'(end_time), 32'(m_done));
`ifdef COUNTER_TIME_WARN_EN
    chk("warn", 32'(warn), 32'(m_dir && !m_done
                                && m_tempo <= WT));
`else
    chk("warn", 32'(warn), 32'(0));
`endif
    if (was_ld)
      chk("sat5", 32'(tempo5), 32'(sat5));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    // up count from reset, then hold after expiry
    R = 1; down = 0; E = 0;
    cyc();
    chk("rst_tempo", 32'(tempo), 32'(0));
    R = 0; E = 1;
    run(80);
    chk("up_final", 32'(tempo), 32'(MT));
    chk("up_end", 32'(end_time), 32'(1));

    // down count through the warning band
    R = 1; down = 1;
    cyc();
    chk("rst_down", 32'(tempo), 32'(MT));
    R = 0;
    run(48);
    chk("down48", 32'(tempo), 32'(WT));
    run(12);
    chk("down60", 32'(tempo), 32'(0));
    chk("down_end", 32'(end_time), 32'(1));
    run(5);

    // pause with partial prescaler progress
    R = 1; down = 0;
    cyc();
    R = 0;
    run(6);
    E = 0;
    run(10);
    chk("pause_hold", 32'(tempo), 32'(1));
    E = 1;
    cyc();
    chk("pause_1", 32'(tick), 32'(0));
    cyc();
    chk("pause_2", 32'(tick), 32'(1));
    run(3);

    // mid-round reload, then a reload to the end value
    load = 1; lv = 9; lv5 = 20; down = 1;
    cyc();
    load = 0;
    chk("ld9", 32'(tempo), 32'(9));
    chk("ld_sat5", 32'(tempo5), 32'(MT));
    run(TD);
    chk("ld9_step", 32'(tempo), 32'(8));
    load = 1; lv = 0;
    cyc();
    load = 0;
    chk("ld0_end", 32'(end_time), 32'(1));
    run(6);

    // reset + load + prescaler terminal on one edge
    R = 1; down = 0;
    cyc();
    R = 0;
    run(TD - 1);
    R = 1; load = 1; lv = 7;
    cyc();
    R = 0; load = 0;
    chk("prio_tempo", 32'(tempo), 32'(0));
    chk("prio_tick", 32'(tick), 32'(0));
    run(10);

    // random control traffic
    for (int i = 0; i < 600; i++) begin
      R = ($urandom % 60) == 0;
      load = ($urandom % 20) == 0;
      E = ($urandom % 5) != 0;
      down = $urandom % 2;
      lv = 4'($urandom);
      lv5 = 5'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
